// File: rtl/bus2st_frm_fifo.sv
// Store-and-forward converter from wide host bus words (header + packed symbols)
// to an Avalon-ST symbol stream, buffering several complete frames with per-frame length.
module bus2st_frm_fifo #(
  parameter int BUS        = 512,
  parameter int BUS_HEAD   = 16,
  parameter int ST         = 24,
  parameter int W_SYM      = 9,
  parameter int FIFO_DEPTH = 64,
  parameter int FRM_DEPTH  = 4,
  parameter int W_LEN      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BUS-1:0]                 bus_data,
  input  logic                           bus_valid,
  output logic                           bus_ready,
  output logic [ST-1:0]                  st_data,
  output logic                           st_valid,
  input  logic                           st_ready,
  output logic                           st_sop,
  output logic                           st_eop,
  output logic [W_LEN-1:0]               st_len,
  output logic [$clog2(FRM_DEPTH+1)-1:0] frm_pending,
  output logic                           err_ovf,
  output logic                           err_cnt,
  output logic [1:0]                     dbg_state
);

  localparam int PW      = BUS - BUS_HEAD;
  localparam int MAX_SYM = PW / ST;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LAW     = $clog2(FRM_DEPTH);
  localparam int CW      = $clog2(FRM_DEPTH + 1);
  localparam int EW      = 1 + W_SYM + PW;
  localparam logic [W_SYM-1:0] MAX_N     = W_SYM'(MAX_SYM);
  localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]    FRM_CNT   = CW'(FRM_DEPTH);

  // Handshakes: a word/symbol moves on a clock edge where valid & ready are both 1;
  // a source never withdraws valid or changes its payload until that transfer happens.

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STREAM = 2'd2} state_t;
  state_t state, state_nx;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]      wptr, rptr, frm_start, wptr_nx, rptr_nx, cnt_nx;
  logic [W_LEN-1:0] lq [FRM_DEPTH];
  logic [LAW-1:0]   lq_wp, lq_rp;
  logic [CW-1:0]    lq_cnt, lq_cnt_nx;
  logic [W_LEN-1:0] acc, acc_sum, len_cur;
  logic [W_LEN:0]   acc_wide;
  logic             discard;

  logic [W_SYM-1:0] n_raw, n_in;
  logic             last_in, bad_n, accept, wr_en, lq_push, flush, hdr_unused;

  logic [PW-1:0]    cur_pay;
  logic [W_SYM-1:0] cur_rem;
  logic             cur_last, first, adv, cur_end, ld_cur, lq_pop;
  logic [EW-1:0]    rd_word;

  assign n_raw      = bus_data[W_SYM-1:0];
  assign last_in    = bus_data[BUS_HEAD-2];
  assign hdr_unused = ^bus_data[BUS_HEAD-1:0];
  assign bad_n      = (n_raw == '0) || (n_raw > MAX_N);
  assign n_in       = bad_n ? MAX_N : n_raw;
  assign accept     = bus_valid & bus_ready;
  assign wr_en      = accept & ~discard;
  assign lq_push    = wr_en & last_in;
  assign acc_wide   = {1'b0, acc} + (W_LEN+1)'(n_in);
  assign acc_sum    = acc_wide[W_LEN] ? '1 : acc_wide[W_LEN-1:0];

  // A full FIFO with the reader idle and no complete frame can only hold one oversized frame.
  assign flush = ((wptr - rptr) == DEPTH_CNT) && (state == IDLE) && (lq_cnt == '0) && !discard;

  assign rd_word = mem[rptr[AW-1:0]];
  assign adv     = (state == STREAM) && (!st_valid || st_ready);
  assign cur_end = (cur_rem == W_SYM'(1));

  assign wptr_nx   = flush ? frm_start : wptr + (AW+1)'(wr_en);
  assign rptr_nx   = rptr + (AW+1)'(ld_cur);
  assign cnt_nx    = wptr_nx - rptr_nx;
  assign lq_cnt_nx = lq_cnt + CW'(lq_push) - CW'(lq_pop);

  always_comb begin
    state_nx = state;
    ld_cur   = 1'b0;
    lq_pop   = 1'b0;
    case (state)
      IDLE:   if (lq_cnt != '0) state_nx = LOAD;
      LOAD: begin
        lq_pop   = 1'b1;
        ld_cur   = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        if (adv && cur_end) begin
          if (cur_last) state_nx = (lq_cnt != '0) ? LOAD : IDLE;
          else          ld_cur   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (wr_en)   mem[wptr[AW-1:0]] <= {last_in, n_in, bus_data[BUS-1:BUS_HEAD]};
    if (lq_push) lq[lq_wp] <= acc_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      frm_start <= '0;
      acc       <= '0;
      discard   <= 1'b0;
      err_ovf   <= 1'b0;
      err_cnt   <= 1'b0;
      lq_wp     <= '0;
      bus_ready <= 1'b0;
    end else begin
      wptr      <= wptr_nx;
      bus_ready <= (cnt_nx != DEPTH_CNT) && (lq_cnt_nx != FRM_CNT);
      if (accept && bad_n) err_cnt <= 1'b1;
      if (flush) begin
        err_ovf <= 1'b1;
        discard <= 1'b1;
        acc     <= '0;
      end else if (accept && discard) begin
        if (last_in) discard <= 1'b0;
      end else if (wr_en) begin
        if (last_in) begin
          acc       <= '0;
          frm_start <= wptr_nx;
          lq_wp     <= lq_wp + LAW'(1);
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  // Symbols leave the low end of cur_pay; the register shifts down one symbol per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      lq_rp    <= '0;
      lq_cnt   <= '0;
      len_cur  <= '0;
      cur_pay  <= '0;
      cur_rem  <= '0;
      cur_last <= 1'b0;
      first    <= 1'b0;
      st_valid <= 1'b0;
      st_data  <= '0;
      st_sop   <= 1'b0;
      st_eop   <= 1'b0;
      st_len   <= '0;
    end else begin
      rptr   <= rptr_nx;
      lq_cnt <= lq_cnt_nx;
      if (lq_pop) begin
        lq_rp   <= lq_rp + LAW'(1);
        len_cur <= lq[lq_rp];
        first   <= 1'b1;
      end
      if (ld_cur) begin
        {cur_last, cur_rem, cur_pay} <= rd_word;
      end else if (adv) begin
        cur_pay <= cur_pay >> ST;
        cur_rem <= cur_rem - W_SYM'(1);
      end
      if (adv) begin
        st_valid <= 1'b1;
        st_data  <= cur_pay[ST-1:0];
        st_sop   <= first;
        st_eop   <= cur_last && cur_end;
        st_len   <= len_cur;
        first    <= 1'b0;
      end else if (st_ready) begin
        st_valid <= 1'b0;
        st_sop   <= 1'b0;
        st_eop   <= 1'b0;
      end
    end
  end

  assign frm_pending = lq_cnt;
  assign dbg_state   = state;

endmodule

// File: tb/tb_bus2st_frm_fifo.sv
// Bench for bus2st_frm_fifo: frame-level model pushes expected beats into a queue,
// a negedge monitor compares every presented beat against the queue head.
module tb_bus2st_frm_fifo;
  localparam int BUS = 512, BUS_HEAD = 16, ST = 24, W_SYM = 9;
  localparam int FIFO_DEPTH = 4, FRM_DEPTH = 4, W_LEN = 16;
  localparam int PW = BUS - BUS_HEAD;
  localparam int MAX_SYM = PW / ST;
  localparam int W = W_LEN + 2 + ST;

  logic                 clk, rst_n;
  logic [BUS-1:0]       bus_data;
  logic                 bus_valid, bus_ready;
  logic [ST-1:0]        st_data;
  logic                 st_valid, st_ready, st_sop, st_eop;
  logic [W_LEN-1:0]     st_len;
  logic [2:0]           frm_pending;
  logic                 err_ovf, err_cnt;
  logic [1:0]           dbg_state;

  bus2st_frm_fifo #(
    .BUS(BUS), .BUS_HEAD(BUS_HEAD), .ST(ST), .W_SYM(W_SYM),
    .FIFO_DEPTH(FIFO_DEPTH), .FRM_DEPTH(FRM_DEPTH), .W_LEN(W_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop), .st_len(st_len), .frm_pending(frm_pending),
    .err_ovf(err_ovf), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 1;  // 0: sink stalled, 1: always ready, 2: random

  initial st_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       st_ready = 1'b0;
      1:       st_ready = 1'b1;
      default: st_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit was_stall = 0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      was_stall = 0;
    end else begin
      if (was_stall) chk("valid_hold", st_valid, 1);
      if (st_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {st_len, st_sop, st_eop, st_data});
        end else begin
          chk("beat", {st_len, st_sop, st_eop, st_data}, exp_q[0]);
          if (st_ready) void'(exp_q.pop_front());
        end
      end
      was_stall = st_valid && !st_ready;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [PW-1:0] rand_pl();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom();
    return t[PW-1:0];
  endfunction

  // Entered just after a negedge; returns just after the negedge following the accept edge.
  task automatic send_bus(input logic last, input logic [W_SYM-1:0] nf, input logic [PW-1:0] pl);
    logic [BUS_HEAD-1:0] hdr;
    bit acc;
    int t;
    hdr = BUS_HEAD'($urandom());
    hdr[W_SYM-1:0] = nf;
    hdr[BUS_HEAD-2] = last;
    bus_data  = {pl, hdr};
    bus_valid = 1'b1;
    acc = 0;
    t = 0;
    while (!acc && t < 500) begin
      acc = bus_ready;
      @(negedge clk);
      t++;
    end
    bus_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL bus_accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic send_frame(input int nb, input int n0, input int n1, input int n2, input int n3,
                            input bit expect_out);
    int nf[4];
    int ne[4];
    logic [PW-1:0] pl[4];
    int len;
    logic s, e;
    nf = '{n0, n1, n2, n3};
    len = 0;
    for (int b = 0; b < nb; b++) begin
      pl[b] = rand_pl();
      ne[b] = (nf[b] == 0 || nf[b] > MAX_SYM) ? MAX_SYM : nf[b];
      len += ne[b];
    end
    if (expect_out) begin
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < ne[b]; k++) begin
          s = (b == 0 && k == 0);
          e = (b == nb - 1 && k == ne[b] - 1);
          exp_q.push_back({W_LEN'(len), s, e, pl[b][k*ST +: ST]});
        end
      end
    end
    for (int b = 0; b < nb; b++) send_bus(b == nb - 1, W_SYM'(nf[b]), pl[b]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, t;
    bus_valid = 1'b0;
    bus_data  = '0;
    rst_n = 1'b0;
    #12;
    chk("reset_outputs",
        {st_valid, st_sop, st_eop, bus_ready, st_len, st_data, frm_pending, err_ovf, err_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus_ready, 1);

    // 45-symbol frame, latency from last bus to sop
    rdy_mode = 1;
    send_frame(3, 20, 20, 5, 0, 1);
    lat = 0;
    while (!st_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, 3);
    chk("first_sop", st_sop, 1);
    wait_drain();

    // same frame shape under random backpressure
    rdy_mode = 2;
    send_frame(3, 20, 20, 5, 0, 1);
    wait_drain();

    // eight single-symbol frames against a stalled sink
    rdy_mode = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_frame(1, 1, 0, 0, 0, 1);
      end
      begin
        t = 0;
        while (frm_pending != 3'd4 && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("pending_full", frm_pending, 4);
        chk("ready_low_len_queue_full", bus_ready, 0);
        rdy_mode = 1;
      end
    join
    wait_drain();
    chk("no_ovf_yet", err_ovf, 0);

    // oversized frame: four fill the FIFO, fifth and the closing last bus are dropped
    for (int i = 0; i < 5; i++) send_bus(1'b0, 9'd3, rand_pl());
    chk("err_ovf_set", err_ovf, 1);
    send_bus(1'b1, 9'd3, rand_pl());
    @(negedge clk);
    chk("pending_after_discard", frm_pending, 0);
    send_frame(2, 6, 9, 0, 0, 1);
    wait_drain();
    chk("no_cnt_err_yet", err_cnt, 0);

    // illegal symbol counts fall back to MAX_SYM
    send_frame(2, 0, 25, 0, 0, 1);
    wait_drain();
    chk("err_cnt_set", err_cnt, 1);

    // random traffic
    rdy_mode = 2;
    for (int f = 0; f < 20; f++) begin
      send_frame($urandom_range(1, 4), $urandom_range(0, 25), $urandom_range(0, 25),
                 $urandom_range(0, 25), $urandom_range(0, 25), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    // reset in the middle of a frame
    rdy_mode = 1;
    send_frame(4, 20, 20, 20, 20, 1);
    t = 0;
    while (!st_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {st_valid, st_sop, st_eop, bus_ready}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", bus_ready, 1);
    chk("errors_cleared", {err_ovf, err_cnt, frm_pending}, 0);
    send_frame(3, 7, 20, 3, 0, 1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
